// File: rtl/serial_alu_pkg.sv
// Shared op codes, FSM encodings and helpers for the bit-serial ALU.
package serial_alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_NOR = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/serial_alu_alu1.sv
// One-bit ALU slice; reserved op codes give out=0, cout=0.
module serial_alu_alu1
    import serial_alu_pkg::*;
(
    output logic       out,
    output logic       cout,
    input  logic       A,
    input  logic       B,
    input  logic       carryin,
    input  logic [2:0] control
);

    always_comb begin
        out  = 1'b0;
        cout = 1'b0;
        case (control)
            ALU_ADD: {cout, out} = {1'b0, A} + {1'b0, B} + {1'b0, carryin};
            ALU_SUB: {cout, out} = {1'b0, A} + {1'b0, ~B} + {1'b0, carryin};
            ALU_AND: out = A & B;
            ALU_OR:  out = A | B;
            ALU_NOR: out = ~(A | B);
            ALU_XOR: out = A ^ B;
            default: begin
                out  = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial WIDTH-bit ALU: one slice, registered carry, LSB first.
//  state  | meaning
//  S_IDLE | waiting for start
//  S_RUN  | one result bit per clock, bit counter counts down to 0
//  S_DONE | one-cycle done pulse; may accept the next op directly
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_out;
    logic             bit_cout;
    logic [WIDTH-1:0] out_next;

    serial_alu_alu1 u_slice (
        .out     (bit_out),
        .cout    (bit_cout),
        .A       (a_q[0]),
        .B       (b_q[0]),
        .carryin (carry),
        .control (op_q)
    );

    // result bits enter at the MSB so bit i lands at out[i] after WIDTH shifts
    assign out_next = {bit_out, out[WIDTH-1:1]};
    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            out      <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= control;
                        carry <= (control == ALU_SUB);
                        cnt   <= CNT_LAST;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    carry <= bit_cout;
                    out   <= out_next;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state    <= S_DONE;
                        zero     <= (out_next == '0);
                        negative <= bit_out;
                        // carry still holds the carry into the MSB here
                        overflow <= op_is_arith(op_q) & (carry ^ bit_cout);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench: three serial_alu instances (WIDTH 2, 8, 32) exercised one at a time.
module tb_serial_alu;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int wid[NI] = '{2, 8, 32};

    logic        rst_v[NI];
    logic        start_v[NI];
    logic [31:0] a_v[NI];
    logic [31:0] b_v[NI];
    logic [2:0]  ctl_v[NI];
    logic        busy_v[NI];
    logic        done_v[NI];
    logic [31:0] out_v[NI];
    logic        ovf_v[NI];
    logic        zero_v[NI];
    logic        neg_v[NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = (g == 0) ? 2 : ((g == 1) ? 8 : 32);
        logic [W-1:0] o;
        serial_alu #(.WIDTH(W)) u_dut (
            .clk      (clk),
            .reset_n  (rst_v[g]),
            .start    (start_v[g]),
            .A        (a_v[g][W-1:0]),
            .B        (b_v[g][W-1:0]),
            .control  (ctl_v[g]),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .out      (o),
            .overflow (ovf_v[g]),
            .zero     (zero_v[g]),
            .negative (neg_v[g])
        );
        assign out_v[g] = 32'(o);
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  e8;
        logic        v8;
    } vec_t;

    // e8/v8: hand-computed result and overflow for WIDTH=8
    vec_t vecs[11] = '{
        '{3'd2, 32'h0000007F, 32'h00000001, 8'h80, 1'b1},
        '{3'd3, 32'h00000005, 32'h00000005, 8'h00, 1'b0},
        '{3'd3, 32'h00000080, 32'h00000001, 8'h7F, 1'b1},
        '{3'd6, 32'h000000F0, 32'h0000000F, 8'h00, 1'b0},
        '{3'd7, 32'h000000A5, 32'h000000FF, 8'h5A, 1'b0},
        '{3'd2, 32'h00000010, 32'h00000020, 8'h30, 1'b0},
        '{3'd4, 32'h0000003C, 32'h0000000F, 8'h0C, 1'b0},
        '{3'd5, 32'h0000003C, 32'h0000000F, 8'h3F, 1'b0},
        '{3'd1, 32'h000000FF, 32'h000000FF, 8'h00, 1'b0},
        '{3'd2, 32'h7FFFFFFF, 32'h00000001, 8'h00, 1'b0},
        '{3'd3, 32'h80000000, 32'h00000001, 8'hFF, 1'b0}
    };

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] ref_alu(input int w, input logic [2:0] op,
                                            input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        logic [31:0] a = a_in & m;
        logic [31:0] b = b_in & m;
        logic [31:0] r;
        logic        v;
        case (op)
            3'd2:    r = a + b;
            3'd3:    r = a - b;
            3'd4:    r = a & b;
            3'd5:    r = a | b;
            3'd6:    r = ~(a | b);
            3'd7:    r = a ^ b;
            default: r = 32'd0;
        endcase
        r = r & m;
        v = 1'b0;
        if (op == 3'd2) v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
        if (op == 3'd3) v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
        return {v, r};
    endfunction

    task automatic get_exp(input int g, input int i, output logic [31:0] eo, output logic ev);
        logic [32:0] r;
        if (wid[g] == 8) begin
            eo = {24'd0, vecs[i].e8};
            ev = vecs[i].v8;
        end else begin
            r  = ref_alu(wid[g], vecs[i].op, vecs[i].a, vecs[i].b);
            eo = r[31:0];
            ev = r[32];
        end
    endtask

    // start driven just after edge 0, accepted at edge 1; done expected after edge W+1
    task automatic run_op(input int g, input int i, input logic repulse);
        int          w = wid[g];
        int          edges;
        int          done_edge = -1;
        logic [31:0] eo;
        logic        ev;
        string       t = $sformatf("w%0d v%0d", w, i);
        get_exp(g, i, eo, ev);
        @(posedge clk); #1;
        a_v[g] = vecs[i].a; b_v[g] = vecs[i].b; ctl_v[g] = vecs[i].op; start_v[g] = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        start_v[g] = 1'b0; a_v[g] = ~vecs[i].a; b_v[g] = ~vecs[i].b; ctl_v[g] = ~vecs[i].op;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_v[g]) begin
                done_edge = edges;
                break;
            end
            @(posedge clk); #1;
            edges++;
            start_v[g] = repulse && (edges == 2 || edges == 3 || edges == 5) && (edges <= w);
        end
        start_v[g] = 1'b0;
        chk({t, " latency"}, 64'(done_edge), 64'(w + 1));
        chk({t, " out"}, 64'(out_v[g]), 64'(eo));
        chk({t, " overflow"}, 64'(ovf_v[g]), 64'(ev));
        chk({t, " zero"}, 64'(zero_v[g]), 64'(eo == 32'd0));
        chk({t, " negative"}, 64'(neg_v[g]), 64'(eo[w-1]));
        @(negedge clk);
        chk({t, " done single"}, 64'(done_v[g]), 64'd0);
        chk({t, " busy idle"}, 64'(busy_v[g]), 64'd0);
        chk({t, " out held"}, 64'(out_v[g]), 64'(eo));
    endtask

    task automatic back_to_back(input int g, input int i, input int j);
        int          w = wid[g];
        int          edges;
        int          e1 = -1;
        int          e2 = -1;
        int          busy_low = 0;
        logic [31:0] eo1, eo2;
        logic        ev1, ev2;
        string       t = $sformatf("w%0d b2b", w);
        get_exp(g, i, eo1, ev1);
        get_exp(g, j, eo2, ev2);
        @(posedge clk); #1;
        a_v[g] = vecs[i].a; b_v[g] = vecs[i].b; ctl_v[g] = vecs[i].op; start_v[g] = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        a_v[g] = vecs[j].a; b_v[g] = vecs[j].b; ctl_v[g] = vecs[j].op;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done_v[g]) begin
                if (e1 < 0) begin
                    e1 = edges;
                    chk({t, " first out"}, 64'(out_v[g]), 64'(eo1));
                end else begin
                    e2 = edges;
                    break;
                end
            end else if (e1 >= 0 && !busy_v[g]) begin
                busy_low++;
            end
            @(posedge clk); #1;
            edges++;
        end
        start_v[g] = 1'b0;
        chk({t, " first latency"}, 64'(e1), 64'(w + 1));
        chk({t, " second latency"}, 64'(e2), 64'(2 * (w + 1)));
        chk({t, " second out"}, 64'(out_v[g]), 64'(eo2));
        chk({t, " second overflow"}, 64'(ovf_v[g]), 64'(ev2));
        chk({t, " busy gaps"}, 64'(busy_low), 64'd0);
        @(negedge clk);
        chk({t, " back to idle"}, 64'(done_v[g] | busy_v[g]), 64'd0);
    endtask

    task automatic reset_mid(input int g);
        int    w  = wid[g];
        int    re = (w >= 4) ? 4 : 2;
        int    dones = 0;
        string t = $sformatf("w%0d rst", w);
        @(posedge clk); #1;
        a_v[g] = 32'h1; b_v[g] = 32'h1; ctl_v[g] = 3'd2; start_v[g] = 1'b1;
        @(posedge clk); #1;
        start_v[g] = 1'b0;
        for (int e = 2; e < re; e++) begin
            @(posedge clk); #1;
        end
        rst_v[g] = 1'b0;
        @(posedge clk); #1;
        rst_v[g] = 1'b1;
        @(negedge clk);
        chk({t, " busy"}, 64'(busy_v[g]), 64'd0);
        chk({t, " out"}, 64'(out_v[g]), 64'd0);
        chk({t, " flags"}, 64'({ovf_v[g], zero_v[g], neg_v[g]}), 64'd0);
        for (int k = 0; k < w + 4; k++) begin
            if (done_v[g]) dones++;
            @(negedge clk);
        end
        chk({t, " no done"}, 64'(dones), 64'd0);
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            rst_v[g] = 1'b0; start_v[g] = 1'b0;
            a_v[g] = '0; b_v[g] = '0; ctl_v[g] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("w%0d reset", wid[g]),
                64'({busy_v[g], done_v[g], ovf_v[g], zero_v[g], neg_v[g]}), 64'd0);
            chk($sformatf("w%0d reset out", wid[g]), 64'(out_v[g]), 64'd0);
            rst_v[g] = 1'b1;
        end
        for (int g = 0; g < NI; g++) begin
            for (int i = 0; i < 11; i++) run_op(g, i, 1'b0);
            run_op(g, 5, 1'b1);
            back_to_back(g, 0, 4);
            run_op(g, 0, 1'b0);
            reset_mid(g);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
